pipelined_rca: RTL and testbench
================================

Name: pipelined_rca

Overview:
- Parametrised, pipelined successor to the fixed 64-bit ripple-carry adder. Adds or subtracts two WIDTH-bit operands.
- The carry chain is split into STAGES equal chunks. Each chunk ripples combinationally and is registered, so only CHUNK = WIDTH/STAGES bits ripple per cycle.
- Valid/ready handshakes on both sides, with per-stage bubble collapsing, let it sit between streaming producers and consumers in the datapath.

Parameters:
- WIDTH, 64, operand/sum width in bits; must be >= 2.
- STAGES, 4, pipeline depth; must be >= 1 and divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  adder can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry in; ignored when sub=1
- sub  input  1  0: a+b+c_in; 1: a-b, i.e. a+~b+1
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- c_out  output  1  carry out of MSB; for sub, 1 = no borrow
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, all stage valid bits and all data registers clear immediately, without waiting for a clock edge. out_valid=0, sum=0, c_out=0, overflow=0. in_ready=1 from the first cycle after release.
- Stages: stage i register (i = 0..STAGES-1) holds:
  - valid_i;
  - sum bits [(i+1)*CHUNK-1:0];
  - the carry out of chunk i;
  - unprocessed upper bits of a and effective b (b, or ~b when sub=1);
  - the sign bits needed for overflow.
- Combinational work per stage: stage 0 ripples chunk 0 from the effective carry-in (c_in, or 1 when sub=1). Stage i>0 ripples chunk i from the carry registered in stage i-1.
- Outputs: sum, c_out and overflow are driven directly from stage STAGES-1. out_valid = valid_{STAGES-1}.
- Handshake:
  - ready_{STAGES} = out_ready; ready_i = !valid_i || ready_{i+1}; in_ready = ready_0. The ready chain is combinational.
  - Stage i loads on an edge when ready_i=1. It captures the upstream valid (in_valid for stage 0) and the upstream data.
  - A transfer occurs when valid && ready are high at a rising edge, on either side.
- Latency and throughput:
  - A transaction accepted at edge E appears with out_valid=1 after edge E+STAGES-1.
  - Throughput is one result per cycle when out_ready=1.
  - STAGES=1 gives a single registered ripple adder.
- Ordering and storage: strictly in-order. No result is dropped or duplicated. Capacity is exactly STAGES transactions.
- Stall behaviour:
  - While out_valid=1 && out_ready=0, the output holds stable: sum, c_out and overflow do not change.
  - Upstream bubbles still collapse. in_ready falls only when all STAGES registers are valid and out_ready=0.
- Simultaneous events: with the pipeline full and out_ready=1, accept and retire happen on the same edge. in_ready stays 1.
- Arithmetic:
  - {c_out, sum} = a + b_eff + cin_eff, computed in WIDTH+1 bits.
  - overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
  - Wrap-around at 2^WIDTH is silent; it is reported only via c_out and overflow.
- Idle outputs: when out_valid=0, the output data is don't-care, except after reset, when it is 0.
- Reset mid-operation: in-flight transactions are discarded. No stale result appears after rst_n returns high.
- Interface rules: inputs are sampled only on accepting edges. A and B may change freely when in_valid=0.

Test Plan:
All scenarios use WIDTH=64, STAGES=4 unless noted.
1. Basic add: a=1, b=1, c_in=1, sub=0 -> sum=3, c_out=0, overflow=0. out_valid rises exactly 3 edges after the accepting edge.
2. Unsigned wrap:
   - a=FFFF_FFFF_FFFF_FFFF, b=1, c_in=1 -> sum=1, c_out=1, overflow=0.
   - a=0123_4567_89AB_CDEF, b=FEDC_BA98_7654_3210, c_in=0 -> sum=FFFF_FFFF_FFFF_FFFF, c_out=0.
   - Same operands with c_in=1 -> sum=0, c_out=1, overflow=0.
3. Subtract:
   - a=5, b=7, sub=1, c_in=1 (ignored) -> sum=FFFF_FFFF_FFFF_FFFE, c_out=0.
   - a=8000_0000_0000_0000, b=1, sub=1 -> sum=7FFF_FFFF_FFFF_FFFF, c_out=1, overflow=1.
   - a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> overflow=1.
4. Backpressure:
   - Stream 8 back-to-back transactions (a=i, b=i, i=1..8) with out_ready=0 for the first 8 cycles -> in_ready falls after exactly 4 accepts, and the first output holds sum=2.
   - Then out_ready=1 -> sums 2,4,...,16 in order, one per cycle. No loss, no duplicate.
5. Bubbles: in_valid toggling 1,0,1,0 with out_ready randomised -> results are in order, and in_ready=0 only when all 4 stages are valid and out_ready=0.
6. Reset:
   - Pull rst_n low asynchronously, mid-cycle, with 3 transactions in flight -> out_valid=0 and sum=0 before the next edge.
   - After release, no result appears until new input is accepted.
   - Repeat test 1 with STAGES=1 (latency 1) and with WIDTH=8, STAGES=2: a=FF, b=01 -> sum=00, c_out=1.

Source files
------------

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit carry chain is cut
// into STAGES equal chunks. Each stage ripples one chunk and registers the
// partial sum, the chunk carry-out and the operand bits still to be added.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Stage i loads whenever ready_i is high, with
// ready_i = !valid_i || ready_{i+1} and ready_STAGES = out_ready, so an empty
// stage always accepts (bubbles collapse) and a full stalled output holds.
module pipelined_rca #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_rca: need WIDTH >= 2, STAGES >= 1 and STAGES dividing WIDTH");
  end

  // Stage registers
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic              ovf_q, ovf_d;

  // Per-stage upstream view and ready chain
  logic [STAGES-1:0] up_valid;
  logic [STAGES-1:0] up_carry;
  logic [WIDTH-1:0]  up_a   [STAGES];
  logic [WIDTH-1:0]  up_b   [STAGES];
  logic [WIDTH-1:0]  up_sum [STAGES];
  logic [STAGES-1:0] stage_ready;
  logic              unused_operand_bits;

  // Ready chain: ready_i is high unless stages i..STAGES-1 are all valid and
  // the consumer stalls; this is the unrolled form of !valid_i || ready_{i+1}.
  always_comb begin : ready_comb
    logic all_valid;
    stage_ready = '0;
    for (int i = 0; i < STAGES; i++) begin
      all_valid = 1'b1;
      for (int j = i; j < STAGES; j++) begin
        all_valid = all_valid & valid_q[j];
      end
      stage_ready[i] = out_ready | ~all_valid;
    end
  end

  // Upstream data for each stage: the ports for stage 0, the previous register otherwise
  always_comb begin
    up_valid  = valid_q;
    up_carry  = carry_q;
    up_valid[0]  = in_valid;
    up_carry[0]  = sub | c_in;
    up_a[0]      = a;
    up_b[0]      = sub ? ~b : b;
    up_sum[0]    = '0;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = valid_q[i-1];
      up_carry[i] = carry_q[i-1];
      up_a[i]     = a_q[i-1];
      up_b[i]     = b_q[i-1];
      up_sum[i]   = sum_q[i-1];
    end
  end

  // Ripple chunk i of each stage and choose load or hold
  always_comb begin : stage_comb
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] new_sum;
    valid_d = valid_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < STAGES; i++) begin
      sum_d[i] = sum_q[i];
      a_d[i]   = a_q[i];
      b_d[i]   = b_q[i];
      chunk_res = {1'b0, up_a[i][i*CHUNK +: CHUNK]}
                + {1'b0, up_b[i][i*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, up_carry[i]};
      new_sum = up_sum[i];
      new_sum[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
      if (stage_ready[i]) begin
        valid_d[i] = up_valid[i];
      end
      // Data only moves with a real transaction, so idle stages keep their
      // contents and the outputs stay at zero after reset until a result lands.
      if (stage_ready[i] && up_valid[i]) begin
        sum_d[i]   = new_sum;
        carry_d[i] = chunk_res[CHUNK];
        a_d[i]     = up_a[i];
        b_d[i]     = up_b[i];
        if (i == STAGES - 1) begin
          ovf_d = (up_a[i][WIDTH-1] == up_b[i][WIDTH-1]) &&
                  (new_sum[WIDTH-1] != up_a[i][WIDTH-1]);
        end
      end
    end
  end

  // Stage registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= '0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= sum_d[i];
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
      end
    end
  end

  // Operand bits already consumed by earlier chunks have no reader; fold them into one named sink
  always_comb begin
    unused_operand_bits = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      unused_operand_bits = unused_operand_bits ^ (^a_q[i]) ^ (^b_q[i]);
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign c_out     = carry_q[STAGES-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: a 64/4 instance carries most scenarios; 64/1 and
// 8/2 instances cover the latency-1 and narrow configurations.
module tb_pipelined_rca;

  localparam int W = 64;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (WIDTH=64, STAGES=4)
  logic         in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, overflow;
  logic [W-1:0] a, b, sum;

  // Single-stage DUT (WIDTH=64, STAGES=1)
  logic         s1_in_valid, s1_in_ready, s1_c_in, s1_sub, s1_out_valid, s1_c_out, s1_overflow;
  logic [W-1:0] s1_a, s1_b, s1_sum;

  // Narrow DUT (WIDTH=8, STAGES=2)
  logic         w8_in_valid, w8_in_ready, w8_c_in, w8_sub, w8_out_valid, w8_c_out, w8_overflow;
  logic [7:0]   w8_a, w8_b, w8_sum;

  pipelined_rca #(.WIDTH(W), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  pipelined_rca #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a(s1_a), .b(s1_b), .c_in(s1_c_in), .sub(s1_sub), .out_valid(s1_out_valid),
    .out_ready(1'b1), .sum(s1_sum), .c_out(s1_c_out), .overflow(s1_overflow)
  );

  pipelined_rca #(.WIDTH(8), .STAGES(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
    .a(w8_a), .b(w8_b), .c_in(w8_c_in), .sub(w8_sub), .out_valid(w8_out_valid),
    .out_ready(1'b1), .sum(w8_sum), .c_out(w8_c_out), .overflow(w8_overflow)
  );

  // Scoreboard state: entries are {overflow, c_out, sum}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] s1_q[$];
  logic [W+1:0] w8_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_pop = 0;
  int   occ   = 0;
  logic rand_en = 1'b0;
  logic stall_prev = 1'b0;
  logic [W+1:0] held;

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [W+1:0] got, input logic [W+1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got ovf/cout/sum %h, required %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Driver: present one transaction, wait (bounded) for acceptance, push its expected result
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    int waited;
    waited = 0;
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready 0 for %0d cycles, required 1", waited);
    end else begin
      exp_q.push_back({eo, ec, es});
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Bounded wait for the main scoreboard to empty
  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk_int(name, exp_q.size(), 0);
  endtask

  // Random consumer backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (rand_en) out_ready = ($urandom_range(0, 1) == 1);
  end

  // Main monitor: in_ready vs occupancy model, stall stability, in-order results
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
      stall_prev = 1'b0;
    end else begin
      chk_bit("in_ready", in_ready, (occ < 4) || out_ready);
      if (stall_prev) begin
        chk_bit("hold_valid", out_valid, 1'b1);
        chk_word("hold_data", {overflow, c_out, sum}, held);
      end
      stall_prev = out_valid && !out_ready;
      held = {overflow, c_out, sum};
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %h, required no output", {overflow, c_out, sum});
        end else begin
          chk_word("result", {overflow, c_out, sum}, exp_q.pop_front());
        end
      end
      occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  // Monitors for the secondary instances
  always @(negedge clk) begin
    if (rst_n && s1_out_valid) begin
      if (s1_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL s1_unexpected: got %h, required no output", s1_sum);
      end else begin
        chk_word("s1_result", {s1_overflow, s1_c_out, s1_sum}, s1_q.pop_front());
      end
    end
    if (rst_n && w8_out_valid) begin
      if (w8_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL w8_unexpected: got %h, required no output", w8_sum);
      end else begin
        chk_word("w8_result", {56'd0, w8_overflow, w8_c_out, w8_sum}, w8_q.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin : stimulus
    int acc_base;
    int pop_base;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    s1_in_valid = 1'b0; s1_a = '0; s1_b = '0; s1_c_in = 1'b0; s1_sub = 1'b0;
    w8_in_valid = 1'b0; w8_a = '0; w8_b = '0; w8_c_in = 1'b0; w8_sub = 1'b0;

    // Reset state
    #1;
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_word("rst_outputs", {overflow, c_out, sum}, '0);
    chk_bit("rst_s1_out_valid", s1_out_valid, 1'b0);
    chk_bit("rst_w8_out_valid", w8_out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic add and latency of 3 edges after acceptance
    send(64'd1, 64'd1, 1'b1, 1'b0, 64'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_bit("latency_early", out_valid, 1'b0);
    @(posedge clk); #1;
    chk_bit("latency_on_time", out_valid, 1'b1);
    @(posedge clk); #1;

    // Unsigned wrap and subtraction, back to back
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 64'd1, 1'b1, 1'b0);
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
    send(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send(64'd10, 64'd3, 1'b0, 1'b1, 64'd7, 1'b1, 1'b0);
    wait_drain("drain_arith");

    // Backpressure: fill with out_ready low, then release
    out_ready = 1'b0;
    acc_base = n_acc;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(64'(i), 64'(i), 1'b0, 1'b0, 64'(2 * i), 1'b0, 1'b0);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        chk_int("bp_accepts", n_acc - acc_base, 4);
        chk_bit("bp_in_ready", in_ready, 1'b0);
        chk_bit("bp_out_valid", out_valid, 1'b1);
        chk_word("bp_first_sum", {overflow, c_out, sum}, {2'b00, 64'd2});
        pop_base = n_pop;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk_int("bp_rate", n_pop - pop_base, 8);
        chk_bit("bp_empty", out_valid, 1'b0);
      end
    join
    wait_drain("drain_bp");

    // Bubbles with random consumer
    rand_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(64'(3 * i), 64'(i), 1'b0, 1'b0, 64'(4 * i), 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    rand_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("drain_bubbles");

    // Asynchronous reset mid-cycle with 3 transactions in flight
    out_ready = 1'b0;
    send(64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0);
    send(64'd100, 64'd200, 1'b0, 1'b0, 64'd300, 1'b0, 1'b0);
    send(64'd1000, 64'd2000, 1'b0, 1'b0, 64'd3000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_bit("pre_reset_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_bit("async_rst_valid", out_valid, 1'b0);
    chk_word("async_rst_outputs", {overflow, c_out, sum}, '0);
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk_bit("post_reset_idle", out_valid, 1'b0);
    send(64'd1, 64'd1, 1'b1, 1'b0, 64'd3, 1'b0, 1'b0);
    wait_drain("drain_after_reset");

    // STAGES=1: latency of one edge
    s1_a = 64'd1; s1_b = 64'd1; s1_c_in = 1'b1; s1_sub = 1'b0; s1_in_valid = 1'b1;
    @(negedge clk);
    chk_bit("s1_in_ready", s1_in_ready, 1'b1);
    s1_q.push_back({2'b00, 64'd3});
    @(posedge clk);
    #1;
    s1_in_valid = 1'b0;
    chk_bit("s1_latency", s1_out_valid, 1'b1);

    // WIDTH=8, STAGES=2: FF + 01 wraps with carry
    w8_a = 8'hFF; w8_b = 8'h01; w8_c_in = 1'b0; w8_sub = 1'b0; w8_in_valid = 1'b1;
    @(negedge clk);
    chk_bit("w8_in_ready", w8_in_ready, 1'b1);
    w8_q.push_back({56'd0, 1'b0, 1'b1, 8'h00});
    @(posedge clk);
    #1;
    w8_in_valid = 1'b0;
    chk_bit("w8_latency_early", w8_out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk_bit("w8_latency_on_time", w8_out_valid, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_int("s1_drained", s1_q.size(), 0);
    chk_int("w8_drained", w8_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
